dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  - Data-memory responder: the target end of the mem_stage data-cache request interface.
//  - Accepts one load/store request per req/gnt handshake and returns a read word or write
//    acknowledge on rvalid a fixed LATENCY cycles later.
//  - Backs a word-addressed on-chip SRAM array; flags out-of-range and misaligned accesses.
//  - Sits between mem_stage and the bus.
//  - Serves as the cache-less data path and as the verification model for mem_stage stalls.
// PARAMETERS
//  ADDR_WIDTH   32             byte-address width
//  DATA_W       32             data word width; DATA_W/8 byte lanes
//  DEPTH_WORDS  1024           SRAM depth in words; power of two
//  BASE_ADDR    32'h8000_0000  byte address of word 0
//  LATENCY      2              handshake-to-rvalid cycles; legal range 1..15
// PORTS
//  clk_i       in   1           clock
//  rst_ni      in   1           reset, asynchronous, active-low
//  dc_req_i    in   1           request valid
//  dc_gnt_o    out  1           request accepted when req&&gnt at posedge
//  dc_we_i     in   1           1=store, 0=load
//  dc_addr_i   in   ADDR_WIDTH  byte address (word-aligned by requester)
//  dc_be_i     in   DATA_W/8    store byte enables; ignored on loads
//  dc_wdata_i  in   DATA_W      store data, lane-aligned
//  dc_rvalid_o out  1           response valid, exactly one cycle per accepted request
//  dc_rdata_o  out  DATA_W      load word; 0 on stores and errors
//  dc_err_o    out  1           access fault, qualified by dc_rvalid_o
// BEHAVIOUR
//  - Reset: clock clk_i; reset rst_ni asynchronous, active-low.
//    - State S_IDLE, dc_rvalid_o=0, dc_rdata_o=0, dc_err_o=0, dc_gnt_o=1.
//    - Latency counter and captured request fields are cleared.
//    - SRAM contents are not reset.
//  - Single outstanding request; FSM S_IDLE -> S_WAIT -> S_RESP.
//    - dc_gnt_o=1 in S_IDLE and S_RESP, 0 in S_WAIT.
//  - Handshake at edge T: capture addr/we/be/wdata; counter <= LATENCY-1.
//    - LATENCY==1: go directly to S_RESP. Otherwise go to S_WAIT.
//  - S_WAIT: counter decrements each cycle; at counter==1, go to S_RESP.
//  - Access commits on the edge entering S_RESP:
//    - Store writes only lanes with be=1.
//    - Load registers the full word into dc_rdata_o.
//    - Loads return the whole word; the requester does byte select and sign extension.
//  - S_RESP: dc_rvalid_o=1 for exactly this cycle, so rvalid is seen at T+LATENCY.
//    - New handshake in S_RESP: capture and reload as from S_IDLE. Back-to-back throughput is 1/LATENCY.
//    - Otherwise go to S_IDLE.
//  - Error when (addr-BASE_ADDR) >= DEPTH_WORDS*4 (unsigned, wrap-safe) or addr[1:0]!=0:
//    - dc_err_o=1 with rvalid; dc_rdata_o=0; SRAM unmodified.
//    - Latency is unchanged.
//  - Store with be=0: no write, normal response, err=0.
//  - Read-after-write: a load granted in the store's S_RESP cycle returns the new data.
//  - req dropped without gnt: nothing captured, no response.
//    - Requester must hold req/addr stable until gnt.
//  - Reset mid-operation: pending request discarded, no rvalid issued.
//    - A partially waited store is not written.
//  - Word index = (addr-BASE_ADDR)[$clog2(DEPTH_WORDS)+1:2].
// CONFIGURATION
//  - DMEM_STALL_INJECT_EN defined:
//    - 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 on reset, steps every cycle.
//    - dc_gnt_o additionally forced 0 when lfsr[1:0]==2'b11, giving ~25% grant backpressure.
//    - Response latency after grant is unchanged.
//  - Undefined: dc_gnt_o depends on FSM state only; no LFSR logic is instantiated.
// TESTING
//  1. Reset then SW 0x8000_0010 be=4'hF wdata=0xDEADBEEF, LW same address
//     -> rvalid at T+2 each; rdata=0xDEADBEEF, err=0.
//  2. SB be=4'b0100 wdata=0x00AA0000 to 0x8000_0010 after test 1, then LW
//     -> rdata=0xDEAABEEF.
//  3. LW 0x8000_1000 (DEPTH=1024, out of range) and LW 0x8000_0002 (misaligned)
//     -> rvalid with err=1, rdata=0; a later in-range read returns unchanged data.
//  4. req held high for 4 back-to-back LWs, LATENCY=2
//     -> gnt pattern 1,0,1,0,1,0,1; four rvalids on consecutive S_RESP cycles.
//     -> Store then load at the same address in a chained handshake returns the stored word.
//  5. Assert rst_ni low during S_WAIT of a SW
//     -> no rvalid; gnt=1 after release; target word reads its old value.
//  6. DMEM_STALL_INJECT_EN, 200 random requests vs a scoreboard
//     -> every grant yields exactly one rvalid LATENCY cycles later; data matches;
//        gnt low seen in S_IDLE.

Source files
------------

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory target for the mem_stage request interface, backed
//               by a word-addressed SRAM with fixed LATENCY and fault flagging.
//               Optional grant backpressure: define DMEM_STALL_INJECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_W      = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    LATENCY     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dc_req_i,
  output logic                  dc_gnt_o,
  input  logic                  dc_we_i,
  input  logic [ADDR_WIDTH-1:0] dc_addr_i,
  input  logic [DATA_W/8-1:0]   dc_be_i,
  input  logic [DATA_W-1:0]     dc_wdata_i,
  output logic                  dc_rvalid_o,
  output logic [DATA_W-1:0]     dc_rdata_o,
  output logic                  dc_err_o
);

  localparam int         c_idx_w    = $clog2(DEPTH_WORDS);
  localparam int         c_nbe      = DATA_W / 8;
  localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                  r_state, w_state_nxt;
  logic [3:0]              r_cnt, w_cnt_nxt;
  logic                    w_hs, w_commit, w_stall;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [c_nbe-1:0]        r_be;
  logic [DATA_W-1:0]       r_wdata;
  logic                    w_a_we;
  logic [ADDR_WIDTH-1:0]   w_a_addr, w_off;
  logic [c_nbe-1:0]        w_a_be;
  logic [DATA_W-1:0]       w_a_wdata;
  logic                    w_err;
  logic [c_idx_w-1:0]      w_idx;
  logic                    r_rvalid, r_err;
  logic [DATA_W-1:0]       r_rdata;
  logic [DATA_W-1:0]       mem [DEPTH_WORDS];

`ifdef DMEM_STALL_INJECT_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_lfsr <= 16'hACE1;
    else         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_stall = &r_lfsr[1:0];
`else
  assign w_stall = 1'b0;
`endif

  assign dc_gnt_o = (r_state != S_WAIT) && !w_stall;
  assign w_hs     = dc_req_i && dc_gnt_o;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        w_state_nxt = S_IDLE;
        if (w_hs) begin
          w_cnt_nxt = c_cnt_init;
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
          w_commit    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_hs) begin
        r_we    <= dc_we_i;
        r_addr  <= dc_addr_i;
        r_be    <= dc_be_i;
        r_wdata <= dc_wdata_i;
      end
    end
  end

  // With single-cycle latency the access commits on the handshake edge itself,
  // before the captured registers hold the request.
  assign w_a_we    = (LATENCY == 1) ? dc_we_i    : r_we;
  assign w_a_addr  = (LATENCY == 1) ? dc_addr_i  : r_addr;
  assign w_a_be    = (LATENCY == 1) ? dc_be_i    : r_be;
  assign w_a_wdata = (LATENCY == 1) ? dc_wdata_i : r_wdata;

  assign w_off = w_a_addr - BASE_ADDR;
  assign w_err = (|w_off[ADDR_WIDTH-1:c_idx_w+2]) || (|w_a_addr[1:0]);
  assign w_idx = w_off[c_idx_w+1:2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_commit;
      r_err    <= w_commit && w_err;
      r_rdata  <= (w_commit && !w_a_we && !w_err) ? mem[w_idx] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && w_commit && w_a_we && !w_err) begin
      for (int i = 0; i < c_nbe; i++) begin
        if (w_a_be[i]) mem[w_idx][8*i +: 8] <= w_a_wdata[8*i +: 8];
      end
    end
  end

  assign dc_rvalid_o = r_rvalid;
  assign dc_rdata_o  = r_rdata;
  assign dc_err_o    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder (directed + random traffic).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        dc_req_i = 1'b0;
  logic        dc_gnt_o;
  logic        dc_we_i = 1'b0;
  logic [31:0] dc_addr_i = '0;
  logic [3:0]  dc_be_i = '0;
  logic [31:0] dc_wdata_i = '0;
  logic        dc_rvalid_o;
  logic [31:0] dc_rdata_o;
  logic        dc_err_o;

  dmem_responder #(
    .ADDR_WIDTH(32), .DATA_W(32), .DEPTH_WORDS(1024), .BASE_ADDR(BASE), .LATENCY(LAT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dc_req_i(dc_req_i), .dc_gnt_o(dc_gnt_o),
    .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_be_i(dc_be_i), .dc_wdata_i(dc_wdata_i),
    .dc_rvalid_o(dc_rvalid_o), .dc_rdata_o(dc_rdata_o), .dc_err_o(dc_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [1024];
  bit          known [1024];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          idle_stalls = 0;

  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_ni && dc_rvalid_o) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_rvalid: got rvalid=1 expected no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rvalid_cycle", 32'(cyc), 32'(e.cyc));
        check("err", {31'd0, dc_err_o}, {31'd0, e.err});
        if (e.chk) check("rdata", dc_rdata_o, e.rdata);
      end
    end
  end

  // Reference: decide the response at grant time; single outstanding keeps order.
  task automatic model(input bit we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] off;
    logic [9:0]  idx;
    off     = addr - BASE;
    idx     = off[11:2];
    e.err   = (off >= 32'd4096) || (addr[1:0] != 2'b00);
    e.rdata = '0;
    e.chk   = 1'b1;
    e.cyc   = cyc + LAT;
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mdl[idx][8*i +: 8] = wdata[8*i +: 8];
        if (be == 4'hF) known[idx] = 1'b1;
      end else begin
        e.rdata = mdl[idx];
        e.chk   = known[idx];
      end
    end
    sb.push_back(e);
  endtask

  // Raise req with the given fields and hold until granted; leaves req high.
  task automatic issue(input bit we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input bit track, output int waits);
    dc_req_i   = 1'b1;
    dc_we_i    = we;
    dc_addr_i  = addr;
    dc_be_i    = be;
    dc_wdata_i = wdata;
    waits      = 0;
    forever begin
      @(negedge clk_i);
      if (dc_gnt_o) break;
      waits++;
      if (waits >= 50) begin
        total++;
        bad++;
        $display("FAIL grant_timeout: got no gnt expected gnt within 50 cycles");
        dc_req_i = 1'b0;
        return;
      end
    end
    if (track) model(we, addr, be, wdata);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    dc_req_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin : stim
    int w;
    int gap;
    for (int i = 0; i < 1024; i++) begin
      mdl[i]   = '0;
      known[i] = 1'b0;
    end

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_rvalid", {31'd0, dc_rvalid_o}, 32'd0);
    check("reset_rdata", dc_rdata_o, 32'd0);
    check("reset_err", {31'd0, dc_err_o}, 32'd0);
    check("reset_gnt", {31'd0, dc_gnt_o}, 32'd1);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Full-word store then load
    issue(1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 1'b1, w);
    idle(3);
    issue(1'b0, 32'h8000_0010, 4'hF, 32'h0, 1'b1, w);
    idle(3);

    // Single-lane store merges into existing word -> DEAABEEF
    issue(1'b1, 32'h8000_0010, 4'b0100, 32'h00AA_0000, 1'b1, w);
    idle(3);
    issue(1'b0, 32'h8000_0010, 4'hF, 32'h0, 1'b1, w);
    idle(3);

    // Faults: out of range, misaligned, below base, aliasing store; data untouched
    issue(1'b0, 32'h8000_1000, 4'hF, 32'h0, 1'b1, w);
    idle(3);
    issue(1'b0, 32'h8000_0002, 4'hF, 32'h0, 1'b1, w);
    idle(3);
    issue(1'b0, 32'h7FFF_FFFC, 4'hF, 32'h0, 1'b1, w);
    idle(3);
    issue(1'b1, 32'h8000_1010, 4'hF, 32'h1234_5678, 1'b1, w);
    idle(3);
    issue(1'b1, 32'h8000_0010, 4'h0, 32'hFFFF_FFFF, 1'b1, w);
    idle(3);
    issue(1'b0, 32'h8000_0010, 4'hF, 32'h0, 1'b1, w);
    idle(3);

    // Back-to-back loads with req held: gnt 1,0,1,0,1,0,1
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, 32'h8000_0010, 4'hF, 32'h0, 1'b1, w);
`ifndef DMEM_STALL_INJECT_EN
      check("b2b_gnt_waits", 32'(w), (k == 0) ? 32'd0 : 32'd1);
`endif
    end
    // Chained store then load: load granted in the store's response cycle
    issue(1'b1, 32'h8000_0030, 4'hF, 32'hCAFE_F00D, 1'b1, w);
    issue(1'b0, 32'h8000_0030, 4'hF, 32'h0, 1'b1, w);
`ifndef DMEM_STALL_INJECT_EN
    check("raw_gnt_waits", 32'(w), 32'd1);
`endif
    idle(3);

    // Reset while a store waits: no response, no write
    issue(1'b1, 32'h8000_0020, 4'hF, 32'h1111_1111, 1'b1, w);
    idle(3);
    issue(1'b1, 32'h8000_0020, 4'hF, 32'h5555_5555, 1'b0, w);
    rst_ni   = 1'b0;
    dc_req_i = 1'b0;
    #1;
    check("midrst_rvalid", {31'd0, dc_rvalid_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("midrst_gnt", {31'd0, dc_gnt_o}, 32'd1);
    idle(3);
    issue(1'b0, 32'h8000_0020, 4'hF, 32'h0, 1'b1, w);
    idle(3);

    // Random mixed traffic
    gap = 2;
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      int          r;
      r = $urandom_range(0, 15);
      if (r == 0)      a = BASE + 32'h1000 + ($urandom & 32'h0FFC);
      else if (r == 1) a = BASE + 4 * $urandom_range(0, 31) + $urandom_range(1, 3);
      else             a = BASE + 4 * $urandom_range(0, 31);
      issue(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, 1'b1, w);
      if (gap >= 2 && w > 0) idle_stalls++;
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(gap);
    end
`ifdef DMEM_STALL_INJECT_EN
    total++;
    if (idle_stalls == 0) begin
      bad++;
      $display("FAIL idle_stall: got %0d idle-state gnt stalls expected at least 1", idle_stalls);
    end
`endif

    idle(10);
    check("drain_outstanding", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
